// File: rtl/fp16_shift_arbiter.sv
// Two-requester round-robin arbiter feeding one shared 11-bit mantissa left shifter
// (explicit or leading-zero shift amount) into a single-entry registered output stage.
module fp16_shift_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [10:0] req0_data,
  input  logic [3:0]  req0_shamt,
  input  logic        req0_auto,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [10:0] req1_data,
  input  logic [3:0]  req1_shamt,
  input  logic        req1_auto,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] out_data,
  output logic [3:0]  out_shamt,
  output logic        out_src,
  output logic        out_zero,
  output logic [7:0]  grant_cnt0,
  output logic [7:0]  grant_cnt1
);

  localparam int unsigned DW = 11;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 8;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [SW-1:0]   out_shamt_q, out_shamt_d;
  logic            out_src_q, out_src_d;
  logic            out_zero_q, out_zero_d;
  logic [CW-1:0]   cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic            accept_c, grant_c, gnt_src_c;
  logic [DW-1:0]   sel_data_c, shifted_c;
  logic [SW-1:0]   sel_shamt_c, lzc_c, shamt_c;
  logic            sel_auto_c;

  // Arbitration, shifter, next-state and output-register updates
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_shamt_d = out_shamt_q;
    out_src_d   = out_src_q;
    out_zero_d  = out_zero_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    lzc_c       = SW'(DW);

    accept_c  = (state_q == EMPTY) || out_ready;
    grant_c   = rst_n && accept_c && (req0_valid || req1_valid);
    gnt_src_c = (req0_valid && req1_valid) ? ptr_q : req1_valid;

    sel_data_c  = gnt_src_c ? req1_data  : req0_data;
    sel_shamt_c = gnt_src_c ? req1_shamt : req0_shamt;
    sel_auto_c  = gnt_src_c ? req1_auto  : req0_auto;

    // Ascending scan: the highest set bit is the last to write the count
    for (int i = 0; i < DW; i++) begin
      if (sel_data_c[i]) lzc_c = SW'(DW - 1 - i);
    end
    shamt_c   = sel_auto_c ? lzc_c : sel_shamt_c;
    shifted_c = (shamt_c >= SW'(DW)) ? '0 : (sel_data_c << shamt_c);

    case (state_q)
      EMPTY:   if (grant_c) state_d = FULL;
      FULL:    if (grant_c) state_d = FULL;
               else if (out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (grant_c) begin
      req0_ready  = !gnt_src_c;
      req1_ready  = gnt_src_c;
      ptr_d       = !gnt_src_c;
      out_data_d  = shifted_c;
      out_shamt_d = shamt_c;
      out_src_d   = gnt_src_c;
      out_zero_d  = (shifted_c == '0);
      if (!gnt_src_c && cnt0_q != '1) cnt0_d = cnt0_q + CW'(1);
      if (gnt_src_c && cnt1_q != '1)  cnt1_d = cnt1_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      ptr_q       <= 1'b0;
      out_data_q  <= '0;
      out_shamt_q <= '0;
      out_src_q   <= 1'b0;
      out_zero_q  <= 1'b0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_shamt_q <= out_shamt_d;
      out_src_q   <= out_src_d;
      out_zero_q  <= out_zero_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign out_valid  = (state_q == FULL);
  assign out_data   = out_data_q;
  assign out_shamt  = out_shamt_q;
  assign out_src    = out_src_q;
  assign out_zero   = out_zero_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_fp16_shift_arbiter.sv
// Directed + random bench for fp16_shift_arbiter using a reference model and
// an expected-result queue popped when the output entry is consumed.
module tb_fp16_shift_arbiter;

  logic        clk, rst_n;
  logic        req0_valid, req0_ready, req0_auto;
  logic [10:0] req0_data;
  logic [3:0]  req0_shamt;
  logic        req1_valid, req1_ready, req1_auto;
  logic [10:0] req1_data;
  logic [3:0]  req1_shamt;
  logic        out_valid, out_ready, out_src, out_zero;
  logic [10:0] out_data;
  logic [3:0]  out_shamt;
  logic [7:0]  grant_cnt0, grant_cnt1;

  typedef struct packed {
    logic [10:0] data;
    logic [3:0]  shamt;
    logic        src;
    logic        zero;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic m_full = 1'b0;
  logic m_ptr = 1'b0;
  int   m_cnt0 = 0;
  int   m_cnt1 = 0;

  fp16_shift_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_shamt(req0_shamt), .req0_auto(req0_auto),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_shamt(req1_shamt), .req1_auto(req1_auto),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_shamt(out_shamt), .out_src(out_src), .out_zero(out_zero),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference result: normalise by repeated doubling, shift by multiplication
  function automatic exp_t model(input logic [10:0] d, input logic [3:0] s, input logic a, input logic src);
    exp_t e;
    int   sh;
    int   v;
    if (a) begin
      sh = 0;
      v  = int'(d);
      if (v == 0) sh = 11;
      else while (v < 1024) begin v = v * 2; sh++; end
    end else sh = int'(s);
    v = (sh >= 11) ? 0 : ((int'(d) * (1 << sh)) % 2048);
    e.data  = 11'(v);
    e.shamt = 4'(sh);
    e.src   = src;
    e.zero  = (v == 0);
    return e;
  endfunction

  task automatic drive(input logic v0, input logic [10:0] d0, input logic [3:0] s0, input logic a0,
                       input logic v1, input logic [10:0] d1, input logic [3:0] s1, input logic a1,
                       input logic ordy);
    req0_valid = v0; req0_data = d0; req0_shamt = s0; req0_auto = a0;
    req1_valid = v1; req1_data = d1; req1_shamt = s1; req1_auto = a1;
    out_ready  = ordy;
  endtask

  // One clock: check DUT against model at negedge, advance model, step past posedge
  task automatic cycle();
    logic accept, g, src;
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_ready0", 32'(req0_ready), 32'd0);
      chk("rst_ready1", 32'(req1_ready), 32'd0);
    end else begin
      accept = !m_full || out_ready;
      g      = accept && (req0_valid || req1_valid);
      src    = (req0_valid && req1_valid) ? m_ptr : req1_valid;
      chk("ready0", 32'(req0_ready), 32'(g && !src));
      chk("ready1", 32'(req1_ready), 32'(g && src));
      chk("out_valid", 32'(out_valid), 32'(m_full));
      chk("grant_cnt0", 32'(grant_cnt0), 32'(m_cnt0));
      chk("grant_cnt1", 32'(grant_cnt1), 32'(m_cnt1));
      if (m_full && exp_q.size() > 0) begin
        chk("out_data", 32'(out_data), 32'(exp_q[0].data));
        chk("out_shamt", 32'(out_shamt), 32'(exp_q[0].shamt));
        chk("out_src", 32'(out_src), 32'(exp_q[0].src));
        chk("out_zero", 32'(out_zero), 32'(exp_q[0].zero));
      end
      if (m_full && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (g) begin
        e = src ? model(req1_data, req1_shamt, req1_auto, 1'b1)
                : model(req0_data, req0_shamt, req0_auto, 1'b0);
        exp_q.push_back(e);
        if (!src && m_cnt0 < 255) m_cnt0++;
        if (src && m_cnt1 < 255) m_cnt1++;
        m_ptr = !src;
      end
      m_full = g ? 1'b1 : (out_ready ? 1'b0 : m_full);
    end
    @(posedge clk);
    if (!rst_n) begin
      m_full = 1'b0; m_ptr = 1'b0; m_cnt0 = 0; m_cnt1 = 0;
      exp_q.delete();
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 11'h123, 4'd1, 0, 1, 11'h456, 4'd2, 0, 1);
    do_reset(2);

    // Single request, explicit shift
    drive(1, 11'h0A5, 4'd3, 0, 0, 11'h0, 4'd0, 0, 1);
    cycle();
    drive(0, 11'h0, 4'd0, 0, 0, 11'h0, 4'd0, 0, 1);
    chk("single_data", 32'(out_data), 32'h528);
    chk("single_shamt", 32'(out_shamt), 32'd3);
    cycle();

    // Auto normalise, then all-zero auto, then over-shift
    drive(0, 11'h0, 4'd0, 0, 1, 11'h013, 4'd9, 1, 1);
    cycle();
    chk("auto_data", 32'(out_data), 32'h4C0);
    chk("auto_shamt", 32'(out_shamt), 32'd6);
    drive(0, 11'h0, 4'd0, 0, 1, 11'h000, 4'd2, 1, 1);
    cycle();
    chk("auto0_shamt", 32'(out_shamt), 32'd11);
    chk("auto0_zero", 32'(out_zero), 32'd1);
    drive(1, 11'h7FF, 4'd12, 0, 0, 11'h0, 4'd0, 0, 1);
    cycle();
    chk("over_zero", 32'(out_zero), 32'd1);
    chk("over_shamt", 32'(out_shamt), 32'd12);
    drive(0, 11'h0, 4'd0, 0, 0, 11'h0, 4'd0, 0, 1);
    cycle();

    // Contention right after reset: 0,1,0,1
    do_reset(1);
    drive(1, 11'h001, 4'd0, 0, 1, 11'h002, 4'd0, 0, 1);
    for (int i = 0; i < 4; i++) cycle();
    chk("cont_cnt0", 32'(grant_cnt0), 32'd2);
    chk("cont_cnt1", 32'(grant_cnt1), 32'd2);

    // Backpressure while FULL with both requesters valid
    drive(1, 11'h00F, 4'd1, 0, 1, 11'h0F0, 4'd2, 0, 0);
    for (int i = 0; i < 5; i++) cycle();
    drive(1, 11'h00F, 4'd1, 0, 1, 11'h0F0, 4'd2, 0, 1);
    cycle();
    drive(0, 11'h0, 4'd0, 0, 0, 11'h0, 4'd0, 0, 1);
    cycle();

    // Reset mid-operation with grant_cnt0=9, then saturation
    do_reset(1);
    drive(1, 11'h055, 4'd0, 0, 0, 11'h0, 4'd0, 0, 1);
    for (int i = 0; i < 9; i++) cycle();
    drive(0, 11'h0, 4'd0, 0, 0, 11'h0, 4'd0, 0, 0);
    cycle();
    chk("pre_rst_cnt0", 32'(grant_cnt0), 32'd9);
    do_reset(1);
    drive(0, 11'h0, 4'd0, 0, 1, 11'h3, 4'd0, 0, 1);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_cnt0", 32'(grant_cnt0), 32'd0);
    drive(1, 11'h3, 4'd0, 0, 1, 11'h3, 4'd0, 0, 1);
    cycle();
    chk("post_rst_ptr_src", 32'(out_src), 32'd0);
    drive(1, 11'h201, 4'd1, 0, 0, 11'h0, 4'd0, 0, 1);
    for (int i = 0; i < 300; i++) cycle();
    chk("sat_cnt0", 32'(grant_cnt0), 32'hFF);

    // Random traffic with valid drops and backpressure
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 11'($urandom), 4'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 11'($urandom), 4'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 2) != 0));
      cycle();
    end
    drive(0, 11'h0, 4'd0, 0, 0, 11'h0, 4'd0, 0, 1);
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp16_shift_arbiter.md
FP16_SHIFT_ARBITER -- requirements
Module: fp16_shift_arbiter

Interface
REQ-001 SHALL have ports (clock and reset first): clk input 1 system clock; rst_n input 1 reset; one clock, reset is synchronous and active-low.
REQ-002 SHALL have per requester i in {0,1}: req<i>_valid input 1 request present; req<i>_ready output 1 request accepted this cycle; req<i>_data input 11 mantissa incl. hidden bit; req<i>_shamt input 4 explicit left-shift amount; req<i>_auto input 1 shift amount = leading-zero count of req<i>_data.
REQ-003 SHALL have: out_valid output 1 result held; out_ready input 1 consumer accepts; out_data output 11 shifted mantissa; out_shamt output 4 shift amount applied; out_src output 1 index of granted requester; out_zero output 1 out_data is all zeros.
REQ-004 SHALL have: grant_cnt0, grant_cnt1 output 8 each, saturating count of grants per requester.

Function
REQ-005 SHALL contain one shared 11-bit logical left shifter; result = data << shamt, zero-filled; shamt >= 11 yields 11'd0.
REQ-006 SHALL hold one output entry; FSM states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-007 SHALL define accept = out_valid==0 or (out_valid and out_ready); a grant is issued only in a cycle where accept=1 and at least one req<i>_valid=1.
REQ-008 SHALL arbitrate round-robin with 1-bit pointer ptr: if both valid, grant ptr; if one valid, grant it; ptr updates to the non-granted index after every grant; ptr unchanged with no grant.
REQ-009 SHALL drive req<i>_ready combinationally = 1 only for the granted requester in that cycle; at most one ready high per cycle; ready never asserted when accept=0.
REQ-010 SHALL register the result on the grant edge: out_data, out_shamt, out_src, out_zero valid the next cycle; latency 1 cycle from handshake to out_valid.
REQ-011 SHALL, with req<i>_auto=1, use shamt = number of leading zeros of req<i>_data counted from bit 10 (0..10); data 11'd0 gives shamt 11 and out_data 0; req<i>_shamt is ignored.
REQ-012 SHALL, with req<i>_auto=0, use req<i>_shamt unmodified (0..15) and report it in out_shamt.
REQ-013 SHALL set out_zero=1 whenever the registered out_data == 0, including data loss from over-shift.
REQ-014 SHALL transition EMPTY->FULL on grant; FULL->EMPTY on out_ready with no grant; FULL->FULL on out_ready with grant (back-to-back, full throughput one per cycle); FULL holds with out_ready=0 and all out_* stable.
REQ-015 SHALL keep out_data/out_shamt/out_src/out_zero stable while out_valid=1 and out_ready=0; requester inputs changing then have no effect.
REQ-016 SHALL increment grant_cnt<i> by 1 on each grant to i, saturating at 8'hFF.
REQ-017 SHALL tolerate req<i>_valid deassertion without handshake (no request is latched unless ready was high).

Reset
REQ-018 SHALL, on clk rising edge with rst_n=0, set state EMPTY, out_valid=0, out_data=0, out_shamt=0, out_src=0, out_zero=0, ptr=0, grant_cnt0=grant_cnt1=0.
REQ-019 SHALL hold req0_ready=req1_ready=0 while rst_n=0; reset mid-transfer discards the held entry with no output.
REQ-020 SHALL accept a grant in the first cycle after rst_n returns to 1.

Verification
REQ-021 Single request: req0 data=11'h0A5, shamt=3, auto=0, out_ready=1 -> req0_ready=1 same cycle; next cycle out_data=11'h528, out_shamt=3, out_src=0, out_zero=0.
REQ-022 Auto normalize: req1 data=11'h013, auto=1 -> out_shamt=6, out_data=11'h4C0, out_src=1; data=0 auto=1 -> out_shamt=11, out_data=0, out_zero=1.
REQ-023 Contention: both valid continuously for 4 cycles after reset, out_ready=1 -> grants 0,1,0,1; out_valid high each cycle after first; grant_cnt0=grant_cnt1=2.
REQ-024 Backpressure: out_ready=0 with FULL and both valid -> no ready asserted, outputs stable 5 cycles; out_ready=1 -> same-cycle new grant, ptr-selected requester.
REQ-025 Over-shift: data=11'h7FF, shamt=12, auto=0 -> out_data=0, out_zero=1, out_shamt=12.
REQ-026 Reset mid-operation: FULL with out_ready=0, grant_cnt0=9, rst_n=0 one cycle -> out_valid=0, counters 0, ptr=0; 300 grants to req0 -> grant_cnt0=8'hFF.
